// File: rtl/usb_tx_sched.sv
// rtl/usb_tx_sched.sv - arbitrates host transactions onto the single tx/rx SIE pair
// SOF (req[0]) wins outright; other requesters round-robin and are held off near end of frame.
module usb_tx_sched #(
  parameter int NREQ            = 3,
  parameter int FRAME_LENGTH    = 100000,
  parameter int FRAME_END_QUIET = 5000,
  parameter int RX_TIMEOUT      = 200,
  parameter int RX_IDLE         = 100,
  parameter int IPG             = 16
) (
  input  logic                    c,
  input  logic                    rst_n,
  input  logic [16:0]             frame_time,
  input  logic                    abort,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_rx,
  input  logic                    tx_sie_done,
  input  logic                    rx_sie_dv,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    tx_start,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         timeout,
  output logic                    busy
);
  localparam int              SW          = $clog2(NREQ);
  localparam logic [16:0]     QUIET_START = 17'(FRAME_LENGTH - FRAME_END_QUIET);
  localparam logic [15:0]     TO_LAST     = 16'(RX_TIMEOUT - 1);
  localparam logic [15:0]     IDLE_LAST   = 16'(RX_IDLE - 1);
  localparam logic [15:0]     GAP_LAST    = 16'(IPG);
  localparam logic [SW-1:0]   LAST_IDX    = SW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE         = NREQ'(1);

  typedef enum logic [2:0] {IDLE, START, TX, RX_WAIT, RX, GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] timeout_q, timeout_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   rr_q, rr_d;
  logic            tx_start_q, tx_start_d;
  logic            rx_exp_q, rx_exp_d;
  logic [15:0]     cnt_q, cnt_d, cnt_inc;

  logic [NREQ-1:0] elig;
  logic            hi_found, lo_found, any_found;
  logic [SW-1:0]   hi_pick, lo_pick, pick;

  // Round robin: lowest eligible index at or above rr_q, else lowest below it.
  always_comb begin
    elig = req;
    if (frame_time > QUIET_START) elig[NREQ-1:1] = '0;
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_found = 1'b0;
    lo_pick  = '0;
    for (int i = NREQ - 1; i >= 1; i--) begin
      if (elig[i]) begin
        if (i >= int'(rr_q)) begin
          hi_found = 1'b1;
          hi_pick  = SW'(i);
        end else begin
          lo_found = 1'b1;
          lo_pick  = SW'(i);
        end
      end
    end
    any_found = elig[0] | hi_found | lo_found;
    if (elig[0])       pick = '0;
    else if (hi_found) pick = hi_pick;
    else               pick = lo_pick;
  end

  // Counters load 1 on entry: the cycle of the triggering event counts as the first elapsed cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    rx_exp_d   = rx_exp_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    done_d     = '0;
    timeout_d  = '0;
    cnt_inc    = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
    if (abort) begin
      state_d = IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_found) begin
            state_d    = START;
            gnt_d      = ONE << pick;
            sel_d      = pick;
            rx_exp_d   = req_rx[pick];
            tx_start_d = 1'b1;
            if (pick != '0) rr_d = (pick == LAST_IDX) ? SW'(1) : pick + SW'(1);
          end
        end
        START: state_d = TX;
        TX: begin
          if (tx_sie_done) begin
            cnt_d = 16'd1;
            if (rx_exp_q) begin
              state_d = RX_WAIT;
            end else begin
              done_d  = gnt_q;
              gnt_d   = '0;
              state_d = GAP;
            end
          end
        end
        RX_WAIT: begin
          if (rx_sie_dv) begin
            state_d = RX;
            cnt_d   = 16'd1;
          end else if (cnt_q >= TO_LAST) begin
            timeout_d = gnt_q;
            gnt_d     = '0;
            state_d   = GAP;
            cnt_d     = 16'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RX: begin
          if (rx_sie_dv) begin
            cnt_d = 16'd1;
          end else if (cnt_q >= IDLE_LAST) begin
            done_d  = gnt_q;
            gnt_d   = '0;
            state_d = GAP;
            cnt_d   = 16'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        GAP: begin
          if (cnt_q >= GAP_LAST) state_d = IDLE;
          else                   cnt_d   = cnt_inc;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      rr_q       <= SW'(1);
      rx_exp_q   <= 1'b0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      done_q     <= '0;
      timeout_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      rr_q       <= rr_d;
      rx_exp_q   <= rx_exp_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign tx_start = tx_start_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb/tb_usb_tx_sched.sv - randomized scoreboard bench for usb_tx_sched
// Transaction-level model predicts grant order/timing and completion kind/timing.
module tb_usb_tx_sched;
  localparam int NREQ            = 3;
  localparam int FRAME_LENGTH    = 100000;
  localparam int FRAME_END_QUIET = 5000;
  localparam int RX_TIMEOUT      = 200;
  localparam int RX_IDLE         = 100;
  localparam int IPG             = 16;

  logic        c = 1'b0;
  logic        rst_n;
  logic [16:0] frame_time;
  logic        abort;
  logic [2:0]  req, req_rx;
  logic        tx_sie_done, rx_sie_dv;
  logic [2:0]  gnt;
  logic [1:0]  sel;
  logic        tx_start;
  logic [2:0]  done, timeout;
  logic        busy;

  typedef struct {int idx; int rx; int nb; int gap;} resp_t;
  typedef struct {int idx; int cyc;} gexp_t;
  typedef struct {int idx; int kind; int cyc;} cexp_t;

  resp_t resp_q[$];
  gexp_t gexp_q[$];
  cexp_t cexp_q[$];

  int cyc = 0;
  int n_tot = 0;
  int n_pass = 0;
  int rr_m = 1;
  int last_cmp = 0;
  bit mon_en = 1'b0;
  bit abort_ok = 1'b0;
  bit abort_armed = 1'b0;
  bit resp_busy = 1'b0;

  usb_tx_sched #(
    .NREQ(NREQ), .FRAME_LENGTH(FRAME_LENGTH), .FRAME_END_QUIET(FRAME_END_QUIET),
    .RX_TIMEOUT(RX_TIMEOUT), .RX_IDLE(RX_IDLE), .IPG(IPG)
  ) dut (
    .c(c), .rst_n(rst_n), .frame_time(frame_time), .abort(abort),
    .req(req), .req_rx(req_rx), .tx_sie_done(tx_sie_done), .rx_sie_dv(rx_sie_dv),
    .gnt(gnt), .sel(sel), .tx_start(tx_start), .done(done), .timeout(timeout), .busy(busy)
  );

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    n_tot++;
    $display("FAIL %s: got %0d expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // Grant order for requests raised together: SOF first, then alternate 1/2 from rr_m.
  task automatic push_model(input logic [2:0] r, input logic [2:0] rx, input bit quiet,
                            input int nb, input int gap, input int first_cyc);
    bit [2:0] pend;
    int i, c0, n;
    c0 = first_cyc;
    pend = r;
    if (quiet) pend[2:1] = 2'b00;
    while (pend != 3'b000) begin
      if (pend[0]) i = 0;
      else begin
        i = pend[rr_m] ? rr_m : 3 - rr_m;
        rr_m = (i == NREQ - 1) ? 1 : i + 1;
      end
      pend[i] = 1'b0;
      n = (nb == -9) ? int'($urandom_range(0, 3)) : nb;
      gexp_q.push_back('{i, c0});
      resp_q.push_back('{i, int'(rx[i]), n, gap});
      c0 = -1;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((gexp_q.size() != 0 || resp_q.size() != 0 || cexp_q.size() != 0 ||
            resp_busy || busy === 1'b1) && k < 20000) begin
      @(negedge c);
      req = req & ~(done | timeout);
      k++;
    end
    chk({name, "_complete"}, 32'(k < 20000), 1);
  endtask

  task automatic run_scen(input string name, input logic [2:0] r, input logic [2:0] rx,
                          input int nb, input int gap);
    @(posedge c); #1;
    push_model(r, rx, frame_time > 17'(FRAME_LENGTH - FRAME_END_QUIET), nb, gap, cyc + 1);
    req_rx = rx;
    req = r;
    drain(name);
  endtask

  // Emulated tx/rx SIE: answers each tx_start and records the completion it implies.
  initial begin : responder
    resp_t e;
    int d, t, last, g;
    tx_sie_done = 1'b0;
    rx_sie_dv = 1'b0;
    forever begin
      @(negedge c);
      if (tx_start === 1'b1 && resp_q.size() != 0) begin
        resp_busy = 1'b1;
        e = resp_q.pop_front();
        d = $urandom_range(1, 20);
        repeat (d) @(posedge c);
        #1 tx_sie_done = 1'b1;
        t = cyc;
        @(posedge c); #1 tx_sie_done = 1'b0;
        if (e.rx == 0) cexp_q.push_back('{e.idx, 0, t + 1});
        else if (e.nb < 0) abort_armed = 1'b1;
        else if (e.nb == 0) cexp_q.push_back('{e.idx, 1, t + RX_TIMEOUT});
        else begin
          last = t;
          for (int b = 0; b < e.nb; b++) begin
            g = (e.gap > 0) ? e.gap : ((b == 0) ? int'($urandom_range(1, RX_TIMEOUT - 1))
                                                : int'($urandom_range(1, RX_IDLE - 1)));
            last = last + g;
            while (cyc < last) begin @(posedge c); #1; end
            rx_sie_dv = 1'b1;
            @(posedge c); #1 rx_sie_dv = 1'b0;
          end
          cexp_q.push_back('{e.idx, 0, last + RX_IDLE});
        end
        resp_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic [2:0] gnt_prev, pulse;
    gexp_t ge;
    cexp_t ce;
    int ecyc;
    gnt_prev = '0;
    forever begin
      @(negedge c);
      pulse = done | timeout;
      if (mon_en) begin
        if (gnt != 3'b000 && gnt != gnt_prev) begin
          if (gexp_q.size() == 0) bad("unexpected_gnt", gnt);
          else begin
            ge = gexp_q.pop_front();
            ecyc = (ge.cyc >= 0) ? ge.cyc : last_cmp + IPG + 1;
            chk("gnt_onehot", gnt, 1 << ge.idx);
            chk("sel", sel, ge.idx);
            chk("tx_start_at_gnt", tx_start, 1);
            chk("gnt_cycle", cyc, ecyc);
          end
        end else if (tx_start === 1'b1) bad("stray_tx_start", tx_start);
        if (gnt_prev != 3'b000 && gnt == 3'b000 && pulse == 3'b000 && !abort_ok)
          bad("gnt_dropped", gnt_prev);
        if (pulse != 3'b000) begin
          if (cexp_q.size() == 0) bad("unexpected_pulse", pulse);
          else begin
            ce = cexp_q.pop_front();
            chk("cmp_grantee", pulse, 1 << ce.idx);
            chk("cmp_kind", 32'(timeout != 3'b000), ce.kind);
            chk("cmp_cycle", cyc, ce.cyc);
            chk("gnt_off_at_cmp", gnt, 0);
            last_cmp = cyc;
          end
        end
      end
      gnt_prev = gnt;
    end
  end

  initial begin : main
    logic [2:0] seen;
    int k;
    rst_n = 1'b0;
    abort = 1'b0;
    req = '0;
    req_rx = '0;
    frame_time = '0;
    repeat (3) @(posedge c);
    @(negedge c);
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    @(posedge c); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    run_scen("rr", 3'b110, 3'b000, -9, 0);
    run_scen("sof_first", 3'b011, 3'b000, -9, 0);
    run_scen("rr_after_sof", 3'b110, 3'b000, -9, 0);

    frame_time = 17'd95001;
    run_scen("quiet_sof", 3'b011, 3'b000, -9, 0);
    seen = '0;
    repeat (300) begin @(negedge c); seen = seen | gnt; end
    chk("quiet_holdoff", seen, 0);
    chk("quiet_idle", busy, 0);
    @(posedge c); #1;
    frame_time = 17'd0;
    push_model(req, req_rx, 1'b0, -9, 0, cyc + 1);
    drain("quiet_wrap");

    frame_time = 17'd95000;
    run_scen("quiet_edge", 3'b010, 3'b000, -9, 0);
    frame_time = 17'd0;
    run_scen("rx_timeout", 3'b100, 3'b100, 0, 0);
    run_scen("rx_three_bytes", 3'b010, 3'b010, 3, 67);

    @(posedge c); #1;
    push_model(3'b010, 3'b010, 1'b0, -1, 0, cyc + 1);
    req_rx = 3'b010;
    req = 3'b010;
    k = 0;
    while (!abort_armed && k < 200) begin @(posedge c); #1; k++; end
    chk("abort_reached_rx_wait", 32'(abort_armed), 1);
    repeat (10) @(posedge c);
    #1;
    abort_ok = 1'b1;
    abort = 1'b1;
    req = '0;
    @(posedge c); #1 abort = 1'b0;
    @(negedge c);
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    seen = '0;
    repeat (260) begin @(negedge c); seen = seen | done | timeout | gnt; end
    chk("abort_silent", seen, 0);
    abort_ok = 1'b0;
    abort_armed = 1'b0;
    run_scen("rr_kept_after_abort", 3'b110, 3'b000, -9, 0);

    for (int s = 0; s < 20; s++) begin
      frame_time = 17'($urandom_range(0, FRAME_LENGTH - FRAME_END_QUIET));
      run_scen("random", 3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), -9, 0);
    end

    mon_en = 1'b0;
    @(posedge c); #1;
    frame_time = 17'd0;
    resp_q.push_back('{2, 0, 0, 0});
    req_rx = '0;
    req = 3'b100;
    k = 0;
    while (gnt !== 3'b100 && k < 50) begin @(negedge c); k++; end
    chk("pre_reset_gnt", gnt, 3'b100);
    @(posedge c); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
